// File: rtl/debug_instr_encoder_pkg.sv
// Shared constants, types and RV32 encoding helpers for the debug
// abstract-command instruction encoder.
package debug_instr_encoder_pkg;

    localparam logic [6:0] opcode_load   = 7'b0000011;
    localparam logic [6:0] opcode_store  = 7'b0100011;
    localparam logic [6:0] opcode_system = 7'b1110011;

    localparam logic [2:0] funct_lw    = 3'b010;
    localparam logic [2:0] funct_sw    = 3'b010;
    localparam logic [2:0] funct_csrrw = 3'b001;
    localparam logic [2:0] funct_csrrs = 3'b010;

    localparam logic [31:0] ebreak_instr    = 32'h00100073;
    localparam logic [4:0]  dbg_scratch_reg = 5'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dbg_enc_state_type;

    typedef struct packed {
        logic        write;
        logic        csr;
        logic [11:0] regno;
    } dbg_cmd_type;

    function automatic logic [31:0] encSw(input logic [11:0] imm,
                                          input logic [4:0]  rs2,
                                          input logic [4:0]  rs1);
        return {imm[11:5], rs2, rs1, funct_sw, imm[4:0], opcode_store};
    endfunction

    function automatic logic [31:0] encLw(input logic [11:0] imm,
                                          input logic [4:0]  rs1,
                                          input logic [4:0]  rd);
        return {imm, rs1, funct_lw, rd, opcode_load};
    endfunction

    function automatic logic [31:0] encCsrrs(input logic [11:0] csr,
                                             input logic [4:0]  rd);
        return {csr, 5'd0, funct_csrrs, rd, opcode_system};
    endfunction

    function automatic logic [31:0] encCsrrw(input logic [11:0] csr,
                                             input logic [4:0]  rs1);
        return {csr, rs1, funct_csrrw, 5'd0, opcode_system};
    endfunction

endpackage

// File: rtl/debug_instr_encoder_rom.sv
// Combinational sequence table: latched command plus step index gives the
// instruction word to issue and whether it is the terminating ebreak.
module debug_instr_rom
    import debug_instr_encoder_pkg::*;
#(
    parameter logic [11:0] DATA_ADDR    = 12'h7F0,
    parameter logic [11:0] SCRATCH_ADDR = 12'h7F4
) (
    input  dbg_cmd_type  cmd_i,
    input  logic [2:0]   step_i,
    output logic [31:0]  instr_o,
    output logic         last_o
);

    // GPR sequences are two words, CSR sequences five; the final slot of each
    // is ebreak, so any step at or past the end maps onto it.
    always_comb begin
        instr_o = ebreak_instr;
        last_o  = 1'b1;
        if (!cmd_i.csr) begin
            if (step_i == 3'd0) begin
                last_o  = 1'b0;
                instr_o = cmd_i.write ? encLw(DATA_ADDR, 5'd0, cmd_i.regno[4:0])
                                      : encSw(DATA_ADDR, cmd_i.regno[4:0], 5'd0);
            end
        end else begin
            case (step_i)
                3'd0: begin
                    last_o  = 1'b0;
                    instr_o = encSw(SCRATCH_ADDR, dbg_scratch_reg, 5'd0);
                end
                3'd1: begin
                    last_o  = 1'b0;
                    instr_o = cmd_i.write ? encLw(DATA_ADDR, 5'd0, dbg_scratch_reg)
                                          : encCsrrs(cmd_i.regno, dbg_scratch_reg);
                end
                3'd2: begin
                    last_o  = 1'b0;
                    instr_o = cmd_i.write ? encCsrrw(cmd_i.regno, dbg_scratch_reg)
                                          : encSw(DATA_ADDR, dbg_scratch_reg, 5'd0);
                end
                3'd3: begin
                    last_o  = 1'b0;
                    instr_o = encLw(SCRATCH_ADDR, 5'd0, dbg_scratch_reg);
                end
                default: begin
                    last_o  = 1'b1;
                    instr_o = ebreak_instr;
                end
            endcase
        end
    end

endmodule

// File: rtl/debug_instr_encoder.sv
// Turns debug abstract register-access commands into RV32 instruction words
// fed to the halted core, then reports completion once the core hits ebreak.
module debug_instr_encoder
    import debug_instr_encoder_pkg::*;
#(
    parameter logic [11:0] DATA_ADDR    = 12'h7F0,
    parameter logic [11:0] SCRATCH_ADDR = 12'h7F4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_csr,
    input  logic [11:0] cmd_regno,
    input  logic        cmd_abort,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        instr_last,
    input  logic        core_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_error
);

    dbg_enc_state_type state_q, state_d;
    dbg_cmd_type       cmd_q, cmd_d;
    logic [2:0]        step_q, step_d;
    logic              err_q, err_d;
    logic [31:0]       romInstr;
    logic              romLast;

    debug_instr_rom #(
        .DATA_ADDR    (DATA_ADDR),
        .SCRATCH_ADDR (SCRATCH_ADDR)
    ) u_rom (
        .cmd_i   (cmd_q),
        .step_i  (step_q),
        .instr_o (romInstr),
        .last_o  (romLast)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            step_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    // Step parks on the ebreak slot rather than wrapping once it is accepted.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        step_d  = step_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d.write = cmd_write;
                    cmd_d.csr   = cmd_csr;
                    cmd_d.regno = cmd_regno;
                    step_d      = 3'd0;
                    if (!cmd_csr && (cmd_regno[11:5] != 7'd0)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    if (romLast) begin
                        state_d = WAIT;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            WAIT: begin
                if (core_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cmd_abort && (state_q != IDLE)) begin
            state_d = IDLE;
            step_d  = 3'd0;
            err_d   = 1'b0;
        end
    end

    always_comb begin
        cmd_ready   = (state_q == IDLE);
        instr_valid = (state_q == ISSUE);
        instr       = (state_q == ISSUE) ? romInstr : 32'd0;
        instr_last  = (state_q == ISSUE) ? romLast : 1'b0;
        rsp_valid   = (state_q == RESP);
        rsp_error   = err_q;
    end

endmodule
